templatized_alu_pipe: RTL and testbench

Parametrised successor to the single-cycle templatized ALU. It adds valid/ready handshakes on both sides, a configurable datapath width, transaction tags, status flags, and an iterative multi-cycle multiply path. It sits between the instruction issue stage and the writeback arbiter, and may stall upstream while a multi-cycle op is in flight.

---
 rtl/templatized_alu_pipe.sv | 191 +++++++++++++++++++
 tb/tb_templatized_alu_pipe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/templatized_alu_pipe.sv
// templatized_alu_pipe: ALU with valid/ready handshakes on both sides, pass-through
// tags, carry/zero/error flags and a registered output stage.
// Optional iterative shift-add multiplier (opcode 9), built only when the macro
// TALU_MUL_EN is defined; otherwise opcode 9 decodes as illegal.
module templatized_alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_err
);

  localparam int SHAMT_W = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3, OP_XOR = 4'd4,
    OP_NOR = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7, OP_SRA = 4'd8, OP_MUL = 4'd9
  } op_e;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_carry;
  logic             r_out_zero;
  logic             r_out_err;

  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_result;
  logic                 w_carry;
  logic                 w_err;
  logic [SHAMT_W-1:0]   w_shamt;
  logic                 w_accept;
  logic                 w_idle;
  logic                 w_is_mul;
  logic                 w_mul_done;
  logic [WIDTH-1:0]     w_mul_result;
  logic [TAG_W-1:0]     w_mul_tag;

  assign w_shamt = in_b[SHAMT_W-1:0];

  // Single-cycle datapath: result, carry and illegal-op flag for the current request.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_sum    = '0;
    w_result = '0;
    w_carry  = 1'b0;
    w_err    = 1'b0;
    case (in_op)
      OP_ADD: begin
        w_sum    = {1'b0, in_a} + {1'b0, in_b};
        w_result = w_sum[WIDTH-1:0];
        w_carry  = w_sum[WIDTH];
      end
      OP_SUB: begin
        // Carry-out of A + ~B + 1: 1 means no borrow.
        w_sum    = {1'b0, in_a} + {1'b0, ~in_b} + (WIDTH+1)'(1);
        w_result = w_sum[WIDTH-1:0];
        w_carry  = w_sum[WIDTH];
      end
      OP_AND: w_result = in_a & in_b;
      OP_OR:  w_result = in_a | in_b;
      OP_XOR: w_result = in_a ^ in_b;
      OP_NOR: w_result = ~(in_a | in_b);
      OP_SLL: w_result = in_a << w_shamt;
      OP_SRL: w_result = in_a >> w_shamt;
      OP_SRA: w_result = WIDTH'($signed(in_a) >>> w_shamt);
`ifdef TALU_MUL_EN
      OP_MUL: ; // produced by the iterative path below
`endif
      default: w_err = 1'b1;
    endcase
  end

`ifdef TALU_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [WIDTH-1:0]   r_ma;
  logic [WIDTH-1:0]   r_mb;
  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_cnt;
  logic [TAG_W-1:0]   r_mtag;
  logic [WIDTH-1:0]   w_acc_next;

  assign w_is_mul     = (in_op == OP_MUL);
  assign w_idle       = (r_state == S_IDLE);
  assign w_acc_next   = r_acc + (r_mb[0] ? r_ma : '0);
  assign w_mul_done   = (r_state == S_MUL) && (r_cnt == '0);
  assign w_mul_result = w_acc_next;
  assign w_mul_tag    = r_mtag;

  // FSM next state: enter MUL on an accepted multiply, leave after the last step.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mul) w_state_next = S_MUL;
      S_MUL:   if (r_cnt == '0)          w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Shift-add multiplier: one partial product per cycle, WIDTH cycles total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ma   <= '0;
      r_mb   <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_mtag <= '0;
    end else if (w_accept && w_is_mul) begin
      r_ma   <= in_a;
      r_mb   <= in_b;
      r_acc  <= '0;
      r_cnt  <= SHAMT_W'(WIDTH - 1);
      r_mtag <= in_tag;
    end else if (r_state == S_MUL) begin
      r_acc <= w_acc_next;
      r_ma  <= r_ma << 1;
      r_mb  <= r_mb >> 1;
      r_cnt <= r_cnt - SHAMT_W'(1);
    end
  end
`else
  assign w_is_mul     = 1'b0;
  assign w_idle       = 1'b1;
  assign w_mul_done   = 1'b0;
  assign w_mul_result = '0;
  assign w_mul_tag    = '0;
`endif

  // Accept only when idle and the output register is empty or draining this cycle.
  assign in_ready = rst_n && w_idle && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Output register: loads single-cycle results or the finished product, holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
      r_out_carry  <= 1'b0;
      r_out_zero   <= 1'b0;
      r_out_err    <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_out_valid  <= 1'b1;
      r_out_result <= w_result;
      r_out_tag    <= in_tag;
      r_out_carry  <= w_carry;
      r_out_zero   <= (w_result == '0);
      r_out_err    <= w_err;
    end else if (w_mul_done) begin
      r_out_valid  <= 1'b1;
      r_out_result <= w_mul_result;
      r_out_tag    <= w_mul_tag;
      r_out_carry  <= 1'b0;
      r_out_zero   <= (w_mul_result == '0);
      r_out_err    <= 1'b0;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;
  assign out_carry  = r_out_carry;
  assign out_zero   = r_out_zero;
  assign out_err    = r_out_err;

endmodule

// File: tb/tb_templatized_alu_pipe.sv
// Directed bench for templatized_alu_pipe (WIDTH=32, TAG_W=4): vector table for the
// single-cycle ops, hand-written sequences for backpressure, MUL and reset.
module tb_templatized_alu_pipe;
  localparam int W  = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_op = '0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;
  logic          out_carry;
  logic          out_zero;
  logic          out_err;

  int checks = 0;
  int errors = 0;

  templatized_alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_carry(out_carry), .out_zero(out_zero), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [TW-1:0] tag;
    logic [W-1:0]  res;
    logic          c;
    logic          z;
    logic          e;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next falling edge: drive and sample point.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  task automatic check_out(input string n, input logic [W-1:0] res, input logic [TW-1:0] tag,
                           input logic c, input logic z, input logic e);
    check({n, "_valid"},  out_valid,  1);
    check({n, "_result"}, out_result, res);
    check({n, "_tag"},    out_tag,    tag);
    check({n, "_carry"},  out_carry,  c);
    check({n, "_zero"},   out_zero,   z);
    check({n, "_err"},    out_err,    e);
  endtask

  initial begin
    int k;
    int ready_low;
    int stale;

    vecs[0]  = '{4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 4'h3, 32'h0000_0000, 1'b1, 1'b1, 1'b0}; // ADD wrap
    vecs[1]  = '{4'd1, 32'h0000_0005, 32'h0000_0007, 4'h4, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}; // SUB borrow
    vecs[2]  = '{4'd8, 32'h8000_0000, 32'h0000_0024, 4'h5, 32'hF800_0000, 1'b0, 1'b0, 1'b0}; // SRA by 4
    vecs[3]  = '{4'd1, 32'h0000_0007, 32'h0000_0005, 4'h6, 32'h0000_0002, 1'b1, 1'b0, 1'b0}; // SUB no borrow
    vecs[4]  = '{4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'h7, 32'hF000_F000, 1'b0, 1'b0, 1'b0}; // AND
    vecs[5]  = '{4'd3, 32'h0F0F_0000, 32'h0000_00F0, 4'h8, 32'h0F0F_00F0, 1'b0, 1'b0, 1'b0}; // OR
    vecs[6]  = '{4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 4'h9, 32'h5555_5555, 1'b0, 1'b0, 1'b0}; // XOR
    vecs[7]  = '{4'd5, 32'h0000_0000, 32'h0000_0000, 4'hA, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}; // NOR
    vecs[8]  = '{4'd6, 32'h0000_0001, 32'h0000_001F, 4'hB, 32'h8000_0000, 1'b0, 1'b0, 1'b0}; // SLL 31
    vecs[9]  = '{4'd7, 32'h8000_0000, 32'h0000_0021, 4'hC, 32'h4000_0000, 1'b0, 1'b0, 1'b0}; // SRL by 1
    vecs[10] = '{4'd12, 32'h0000_0005, 32'h0000_0006, 4'hD, 32'h0000_0000, 1'b0, 1'b1, 1'b1}; // illegal
    vecs[11] = '{4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 4'hE, 32'h8000_0000, 1'b0, 1'b0, 1'b0}; // ADD no carry
    vecs[12] = '{4'd4, 32'h1234_5678, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b0, 1'b1, 1'b0}; // XOR zero

    // Reset state
    #1;
    check("rst_in_ready",  in_ready,   0);
    check("rst_out_valid", out_valid,  0);
    check("rst_result",    out_result, 0);
    check("rst_tag",       out_tag,    0);
    check("rst_carry",     out_carry,  0);
    check("rst_zero",      out_zero,   0);
    check("rst_err",       out_err,    0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Back-to-back single-cycle vectors with out_ready held high
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].tag, vecs[i].c, vecs[i].z, vecs[i].e);
    end
    in_valid = 1'b0;
    step();
    check("drain_valid_drop", out_valid, 0);

    // Backpressure: AND result held for 3+ cycles while OR waits
    drive(4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'h9);
    step();
    out_ready = 1'b0;
    drive(4'd3, 32'h1234_0000, 32'h0000_5678, 4'hA);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("hold%0d_in_ready", i), in_ready, 0);
      check_out($sformatf("hold%0d", i), 32'h00F0_00F0, 4'h9, 1'b0, 1'b0, 1'b0);
      if (i < 3) step();
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check_out("queued_or", 32'h1234_5678, 4'hA, 1'b0, 1'b0, 1'b0);
    step();
    check("queued_or_drop", out_valid, 0);

`ifdef TALU_MUL_EN
    // Iterative multiply: 32 stall cycles, result 33 cycles after accept
    drive(4'd9, 32'h0000_1234, 32'h0000_0010, 4'h5);
    step();
    in_valid  = 1'b0;
    k         = 1;
    ready_low = 0;
    while (!out_valid && k < 100) begin
      if (!in_ready) ready_low++;
      step();
      k++;
    end
    check("mul_latency",   k,         33);
    check("mul_ready_low", ready_low, 32);
    check_out("mul", 32'h0001_2340, 4'h5, 1'b0, 1'b0, 1'b0);
    step();
    check("mul_drop", out_valid, 0);

    // Start a multiply that reset will abandon
    drive(4'd9, 32'h0000_00FF, 32'h0000_00FF, 4'h6);
    step();
    in_valid = 1'b0;
    repeat (10) step();
`else
    // Opcode 9 without the multiplier is illegal, latency 1
    drive(4'd9, 32'h0000_0003, 32'h0000_0004, 4'h2);
    step();
    in_valid = 1'b0;
    check_out("op9_illegal", 32'h0000_0000, 4'h2, 1'b0, 1'b1, 1'b1);
    step();
`endif

    // Reset pulse, then no stale output, then ADD 2+3
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready",  in_ready,  0);
    step();
    check("mid_rst_out_valid2", out_valid, 0);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) stale++;
    end
    check("no_stale_result", stale, 0);
    drive(4'd0, 32'h0000_0002, 32'h0000_0003, 4'h7);
    step();
    in_valid = 1'b0;
    check_out("post_rst_add", 32'h0000_0005, 4'h7, 1'b0, 1'b0, 1'b0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
